// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, decoder handoff and redirect inputs.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [31:0]        if_pc;
    logic [31:0]        if_pc4;
    logic               id_ready;
    logic               jump;
    logic [31:0]        jump_target;
    logic               br_taken;
    logic [31:0]        br_target;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
        input  imem_ack, imem_rdata, id_ready, jump, jump_target, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
        output imem_ack, imem_rdata, id_ready, jump, jump_target, br_taken, br_target
    );

endinterface

// File: rtl/fetch_pc_sel.sv
// Next-PC selection: sequential increment plus redirect target (jump over branch, word aligned).
module fetch_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o,
    output logic [31:0] pc_inc_o
);

    always_comb begin
        redirect_o    = jump_i | br_taken_i;
        target_o      = jump_i ? jump_target_i : br_target_i;
        target_o[1:0] = 2'b00;
        pc_inc_o      = pc_i + PC_INC;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: issues word fetches, holds one instruction for decode, handles redirects.
// Optional IFETCH_PERF_EN adds a fetch_count output counting consumed instructions.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]   fetch_count
`endif
);

    localparam logic [31:0] ResetPcAl = {RESET_PC[31:2], 2'b00};

    fetch_state_e       state_q;
    logic [31:0]        pc_q;
    logic               imem_req_q;
    logic [31:0]        imem_addr_q;
    logic               if_valid_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic [31:0]        if_pc_q;
    logic [31:0]        if_pc4_q;

    logic               redirect;
    logic [31:0]        target;
    logic [31:0]        pc_inc;

    fetch_pc_sel u_pc_sel (
        .pc_i          (pc_q),
        .jump_i        (bus.jump),
        .jump_target_i (bus.jump_target),
        .br_taken_i    (bus.br_taken),
        .br_target_i   (bus.br_target),
        .redirect_o    (redirect),
        .target_o      (target),
        .pc_inc_o      (pc_inc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= ResetPcAl;
            imem_req_q  <= 1'b0;
            imem_addr_q <= ResetPcAl;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= 32'h0;
            if_pc4_q    <= PC_INC;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q    <= StReq;
                    imem_req_q <= 1'b1;
                    if (redirect) begin
                        pc_q        <= target;
                        imem_addr_q <= target;
                    end else begin
                        imem_addr_q <= pc_q;
                    end
                end
                StReq: begin
                    if (redirect) begin
                        pc_q <= target;
                        // Data arriving with a redirect is wrong-path; refetch at once.
                        if (bus.imem_ack) begin
                            imem_addr_q <= target;
                        end else begin
                            state_q <= StDrop;
                        end
                    end else if (bus.imem_ack) begin
                        state_q    <= StHold;
                        imem_req_q <= 1'b0;
                        if_valid_q <= 1'b1;
                        if_instr_q <= bus.imem_rdata;
                        if_pc_q    <= pc_q;
                        if_pc4_q   <= pc_inc;
                        pc_q       <= pc_inc;
                    end
                end
                StHold: begin
                    if (redirect || bus.id_ready) begin
                        state_q    <= StReq;
                        imem_req_q <= 1'b1;
                        if_valid_q <= 1'b0;
                        if (redirect) begin
                            pc_q        <= target;
                            imem_addr_q <= target;
                        end else begin
                            imem_addr_q <= pc_q;
                        end
                    end
                end
                StDrop: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    // Old request stays on the bus until its ack, which is then thrown away.
                    if (bus.imem_ack) begin
                        state_q     <= StReq;
                        imem_addr_q <= redirect ? target : pc_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q <= 32'h0;
        end else if (state_q == StHold && bus.id_ready && !redirect) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_pc4    = if_pc4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level reference model.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_if if1 ();
    instr_fetch_if if2 ();

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count1;
    logic [31:0] fetch_count2;
`endif

    instr_fetch u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (if1.master)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count (fetch_count1)
`endif
    );

    // Second instance exercises PC wrap from the top of the address space.
    instr_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (if2.master)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count (fetch_count2)
`endif
    );

    assign if2.imem_ack    = if2.imem_req;
    assign if2.imem_rdata  = if2.imem_addr ^ 32'hA5A5_0000;
    assign if2.id_ready    = 1'b1;
    assign if2.jump        = 1'b0;
    assign if2.jump_target = 32'h0;
    assign if2.br_taken    = 1'b0;
    assign if2.br_target   = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a fetch is either outstanding (possibly stale) or an instruction is held.
    bit          m_started;
    bit          m_fetching;
    bit          m_stale;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_count;

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = if1.jump | if1.br_taken;
        tgt   = (if1.jump ? if1.jump_target : if1.br_target) & 32'hFFFF_FFFC;
        if (!rst_n) begin
            m_started  = 0;
            m_fetching = 0;
            m_stale    = 0;
            m_valid    = 0;
            m_pc       = 32'h0;
            m_addr     = 32'h0;
            m_instr    = 32'h0;
            m_ipc      = 32'h0;
            m_count    = 32'h0;
        end else if (!m_started) begin
            m_started = 1;
            if (redir) m_pc = tgt;
            m_fetching = 1;
            m_addr     = m_pc;
        end else if (m_valid) begin
            if (redir || if1.id_ready) begin
                if (redir) m_pc = tgt;
                else m_count = m_count + 1;
                m_valid    = 0;
                m_fetching = 1;
                m_stale    = 0;
                m_addr     = m_pc;
            end
        end else if (m_fetching) begin
            if (if1.imem_ack) begin
                if (m_stale || redir) begin
                    if (redir) m_pc = tgt;
                    m_stale = 0;
                    m_addr  = m_pc;
                end else begin
                    m_fetching = 0;
                    m_valid    = 1;
                    m_instr    = if1.imem_rdata;
                    m_ipc      = m_addr;
                    m_pc       = m_addr + 32'd4;
                end
            end else if (redir) begin
                m_pc    = tgt;
                m_stale = 1;
            end
        end
    endtask

    initial begin
        int  ack_pct, rdy_pct, redir_pct, rst_pct, spur_pct;
        bit  w_seen_v, w_seen_a;
        w_seen_v = 0;
        w_seen_a = 0;

        rst_n           = 1'b0;
        if1.imem_ack    = 1'b0;
        if1.imem_rdata  = 32'h0;
        if1.id_ready    = 1'b0;
        if1.jump        = 1'b0;
        if1.jump_target = 32'h0;
        if1.br_taken    = 1'b0;
        if1.br_target   = 32'h0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            case (cyc / 500)
                0: begin ack_pct = 100; rdy_pct = 100; redir_pct = 0;  rst_pct = 0; spur_pct = 0;  end
                1: begin ack_pct = 25;  rdy_pct = 15;  redir_pct = 0;  rst_pct = 0; spur_pct = 0;  end
                2: begin ack_pct = 40;  rdy_pct = 50;  redir_pct = 25; rst_pct = 0; spur_pct = 20; end
                3: begin ack_pct = 30;  rdy_pct = 40;  redir_pct = 15; rst_pct = 3; spur_pct = 20; end
                default: begin ack_pct = 60; rdy_pct = 70; redir_pct = 8; rst_pct = 2; spur_pct = 10; end
            endcase

            rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(99) >= rst_pct);
            if (if1.imem_req) if1.imem_ack = ($urandom_range(99) < ack_pct);
            else              if1.imem_ack = ($urandom_range(99) < spur_pct);
            if1.imem_rdata  = $urandom();
            if1.id_ready    = ($urandom_range(99) < rdy_pct);
            if1.jump        = ($urandom_range(99) < redir_pct);
            if1.br_taken    = ($urandom_range(99) < redir_pct);
            if1.jump_target = $urandom();
            if1.br_target   = $urandom();

            @(posedge clk);
            model_step();
            #1;
            check_eq("imem_req",  {31'h0, if1.imem_req}, {31'h0, m_fetching});
            check_eq("imem_addr", if1.imem_addr, m_addr);
            check_eq("if_valid",  {31'h0, if1.if_valid}, {31'h0, m_valid});
            check_eq("if_instr",  if1.if_instr, m_instr);
            check_eq("if_pc",     if1.if_pc, m_ipc);
            check_eq("if_pc4",    if1.if_pc4, m_ipc + 32'd4);
`ifdef IFETCH_PERF_EN
            check_eq("fetch_count", fetch_count1, m_count);
`endif

            if (cyc < 12) begin
                if (!w_seen_v && if2.if_valid) begin
                    check_eq("wrap_if_pc",  if2.if_pc, 32'hFFFF_FFFC);
                    check_eq("wrap_if_pc4", if2.if_pc4, 32'h0);
                    w_seen_v = 1;
                end else if (w_seen_v && !w_seen_a && if2.imem_req) begin
                    check_eq("wrap_addr2", if2.imem_addr, 32'h0);
                    w_seen_a = 1;
                end
            end else if (cyc == 12) begin
                check_eq("wrap_progress", {31'h0, w_seen_a}, 32'h1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset (word aligned).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-005 imem_addr  output  32  SHALL be the instruction-memory word address (bits[1:0] always 0).
REQ-006 imem_ack  input  1  SHALL be the memory completion strobe, one cycle, any latency >= 0 cycles after request.
REQ-007 imem_rdata  input  32  SHALL be the instruction word, valid when imem_ack=1.
REQ-008 if_valid  output  1  SHALL mark if_instr/if_pc as holding a live instruction for the decoder.
REQ-009 if_instr  output  32  SHALL be the fetched instruction driven to the control decoder.
REQ-010 if_pc, if_pc4  output  32 each  SHALL be the instruction's PC and PC+4.
REQ-011 id_ready  input  1  SHALL indicate the decoder consumes the held instruction this cycle.
REQ-012 jump, jump_target  input  1/32  SHALL request a jump redirect to jump_target.
REQ-013 br_taken, br_target  input  1/32  SHALL request a resolved beq/bne redirect to br_target.

Function
REQ-014 States SHALL be IDLE, REQ, HOLD, DROP; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-015 In REQ, imem_req SHALL be 1 and imem_addr=pc, both stable until imem_ack.
REQ-016 REQ with imem_ack and no redirect SHALL load if_instr=imem_rdata, if_pc=pc, set if_valid, pc<=pc+4, go HOLD.
REQ-017 In HOLD, if_valid/if_instr/if_pc SHALL stay stable until if_valid&&id_ready, then clear if_valid and go REQ.
REQ-018 Redirect = jump|br_taken; jump SHALL win when both are asserted; target bits[1:0] SHALL be forced to 0.
REQ-019 Redirect in HOLD SHALL set pc<=target, clear if_valid next cycle regardless of id_ready, go REQ.
REQ-020 Redirect in REQ with imem_ack same cycle SHALL discard imem_rdata, pc<=target, stay REQ.
REQ-021 Redirect in REQ without imem_ack SHALL set pc<=target and go DROP.
REQ-022 DROP SHALL keep imem_req=1 with the old address until imem_ack, discard that data, then go REQ with the new pc.
REQ-023 Redirect in DROP SHALL overwrite the pending target (latest wins).
REQ-024 Redirect in IDLE SHALL set pc<=target before the first request.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0); if_pc4 likewise.
REQ-026 imem_ack outside REQ/DROP SHALL be ignored.

Reset
REQ-027 rst_n=0 at any edge, in any state including mid-request, SHALL give: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc4=4.
REQ-028 An imem_ack arriving in the reset cycle SHALL be dropped.

Configuration
REQ-029 With IFETCH_PERF_EN defined, output fetch_count (32) SHALL count instructions consumed (if_valid&&id_ready, not flushed), reset 0, wrapping.
REQ-030 Without IFETCH_PERF_EN the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, INSTR_W=32, PC_INC=4 and default RESET_PC.
REQ-032 Next-PC selection (pc+4 / jump / branch, priority, alignment) SHALL be sub-module fetch_pc_sel; FSM and registers stay in instr_fetch.

Verification
REQ-033 Reset, ack latency 0, id_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc matches; one instruction per 2 cycles.
REQ-034 Ack latency 3, id_ready low 5 cycles -> if_instr/if_pc held stable, no new imem_req until consumed.
REQ-035 jump=1 target 0x0000_0103 while in HOLD at pc 0x10 -> if_valid drops, next imem_addr=0x0000_0100.
REQ-036 br_taken target 0x40 while REQ waits on ack -> DROP, old data discarded, next imem_addr=0x40; jump+br_taken same cycle -> jump_target used.
REQ-037 RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0, if_pc4=0x0 for first instruction.
REQ-038 rst_n low mid-DROP with ack in same cycle -> all outputs at reset values, fetch restarts at RESET_PC; with IFETCH_PERF_EN fetch_count=0.
